// File: rtl/zx_ram_arbiter_if.sv
// Bus bundle between the CPU/video fetch path, the tape DMA writer, the arbiter and the SDRAM block.
// The arbiter takes the slave view; the surrounding system (requesters and memory) takes the master view.
interface zx_ram_arbiter_if #(
    parameter int AW = 16
) ();
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic [7:0]    cpu_dout;
    logic          cpu_ack;
    logic          dma_req;
    logic [AW-1:0] dma_addr;
    logic [7:0]    dma_din;
    logic          dma_ack;
    logic          mem_rd;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic [7:0]    mem_dout;
    logic          mem_ready;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        output cpu_dout, cpu_ack,
        input  dma_req, dma_addr, dma_din,
        output dma_ack,
        output mem_rd, mem_we, mem_addr, mem_din,
        input  mem_dout, mem_ready
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        input  cpu_dout, cpu_ack,
        output dma_req, dma_addr, dma_din,
        input  dma_ack,
        input  mem_rd, mem_we, mem_addr, mem_din,
        output mem_dout, mem_ready
    );
endinterface

// File: rtl/zx_ram_arbiter.sv
// Sequenced, handshaked grant of the single SDRAM port between the CPU/video path and the tape DMA writer.
// Define ARB_RDCACHE_EN to add a one-entry CPU read buffer that short-circuits repeated reads.
module zx_ram_arbiter #(
    parameter int AW           = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk_sys,
    input  logic            reset,
    zx_ram_arbiter_if.slave bus,
    output logic            grant_dma,
    output logic            busy
);
    localparam int            SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CPU_CMD  = 3'd1,
        CPU_WAIT = 3'd2,
        DMA_CMD  = 3'd3,
        DMA_WAIT = 3'd4,
        CPU_HIT  = 3'd5,
        ACK      = 3'd6
    } state_t;

    state_t        state_r, state_s;
    logic          mem_rd_r, mem_rd_s;
    logic          mem_we_r, mem_we_s;
    logic [AW-1:0] mem_addr_r, mem_addr_s;
    logic [7:0]    mem_din_r, mem_din_s;
    logic [7:0]    cpu_dout_r, cpu_dout_s;
    logic          cpu_ack_r, cpu_ack_s;
    logic          dma_ack_r, dma_ack_s;
    logic          grant_dma_r, grant_dma_s;
    logic          busy_r, busy_s;
    logic          cpu_rd_r, cpu_rd_s;
    logic [SW-1:0] starve_cnt_r, starve_cnt_s;
    logic          dma_win_s;
    logic          cpu_win_s;
    logic          hit_s;
    logic [7:0]    hit_data_s;

    // DMA wins when it has starved long enough or the CPU is not asking
    assign dma_win_s = (state_r == IDLE) && bus.dma_req &&
                       ((starve_cnt_r == STARVE_MAX) || !bus.cpu_req);
    assign cpu_win_s = (state_r == IDLE) && bus.cpu_req && !dma_win_s;

    // Starvation counter: counts CPU wins while DMA is waiting, saturating at the limit
    always_comb begin
        if (!bus.dma_req) begin
            starve_cnt_s = '0;
        end else if (dma_win_s) begin
            starve_cnt_s = '0;
        end else if (cpu_win_s && (starve_cnt_r != STARVE_MAX)) begin
            starve_cnt_s = starve_cnt_r + STARVE_ONE;
        end else begin
            starve_cnt_s = starve_cnt_r;
        end
    end

    // Next-state and next-output logic; every output is registered from these values
    always_comb begin
        state_s     = state_r;
        mem_rd_s    = mem_rd_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_din_s   = mem_din_r;
        cpu_dout_s  = cpu_dout_r;
        cpu_ack_s   = 1'b0;
        dma_ack_s   = 1'b0;
        grant_dma_s = grant_dma_r;
        busy_s      = busy_r;
        cpu_rd_s    = cpu_rd_r;
        case (state_r)
            IDLE: begin
                if (dma_win_s) begin
                    state_s     = DMA_CMD;
                    mem_rd_s    = 1'b0;
                    mem_we_s    = 1'b1;
                    mem_addr_s  = bus.dma_addr;
                    mem_din_s   = bus.dma_din;
                    grant_dma_s = 1'b1;
                    busy_s      = 1'b1;
                    cpu_rd_s    = 1'b0;
                end else if (cpu_win_s && hit_s) begin
                    state_s = CPU_HIT;
                    busy_s  = 1'b1;
                end else if (cpu_win_s) begin
                    state_s    = CPU_CMD;
                    mem_rd_s   = !bus.cpu_we;
                    mem_we_s   = bus.cpu_we;
                    mem_addr_s = bus.cpu_addr;
                    mem_din_s  = bus.cpu_din;
                    busy_s     = 1'b1;
                    cpu_rd_s   = !bus.cpu_we;
                end else begin
                    state_s = IDLE;
                end
            end
            CPU_CMD, DMA_CMD: begin
                if (bus.mem_ready) begin
                    state_s  = (state_r == CPU_CMD) ? CPU_WAIT : DMA_WAIT;
                    mem_rd_s = 1'b0;
                    mem_we_s = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            CPU_WAIT: begin
                if (bus.mem_ready) begin
                    state_s   = ACK;
                    cpu_ack_s = 1'b1;
                    if (cpu_rd_r) begin
                        cpu_dout_s = bus.mem_dout;
                    end else begin
                        cpu_dout_s = cpu_dout_r;
                    end
                end else begin
                    state_s = CPU_WAIT;
                end
            end
            DMA_WAIT: begin
                if (bus.mem_ready) begin
                    state_s     = ACK;
                    dma_ack_s   = 1'b1;
                    grant_dma_s = 1'b0;
                end else begin
                    state_s = DMA_WAIT;
                end
            end
            CPU_HIT: begin
                state_s    = ACK;
                cpu_ack_s  = 1'b1;
                cpu_dout_s = hit_data_s;
            end
            ACK: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
            default: begin
                state_s     = IDLE;
                mem_rd_s    = 1'b0;
                mem_we_s    = 1'b0;
                grant_dma_s = 1'b0;
                busy_s      = 1'b0;
            end
        endcase
    end

    // State, starvation counter and registered outputs
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r      <= IDLE;
            mem_rd_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_din_r    <= 8'h00;
            cpu_dout_r   <= 8'h00;
            cpu_ack_r    <= 1'b0;
            dma_ack_r    <= 1'b0;
            grant_dma_r  <= 1'b0;
            busy_r       <= 1'b0;
            cpu_rd_r     <= 1'b0;
            starve_cnt_r <= '0;
        end else begin
            state_r      <= state_s;
            mem_rd_r     <= mem_rd_s;
            mem_we_r     <= mem_we_s;
            mem_addr_r   <= mem_addr_s;
            mem_din_r    <= mem_din_s;
            cpu_dout_r   <= cpu_dout_s;
            cpu_ack_r    <= cpu_ack_s;
            dma_ack_r    <= dma_ack_s;
            grant_dma_r  <= grant_dma_s;
            busy_r       <= busy_s;
            cpu_rd_r     <= cpu_rd_s;
            starve_cnt_r <= starve_cnt_s;
        end
    end

`ifdef ARB_RDCACHE_EN
    logic [AW-1:0] buf_tag_r;
    logic [7:0]    buf_data_r;
    logic          buf_valid_r;

    assign hit_s      = buf_valid_r && !bus.cpu_we && (bus.cpu_addr == buf_tag_r);
    assign hit_data_s = buf_data_r;

    // Read buffer: loaded by each completed CPU read, dropped by any granted write
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            buf_valid_r <= 1'b0;
            buf_tag_r   <= '0;
            buf_data_r  <= 8'h00;
        end else if (dma_win_s || (cpu_win_s && bus.cpu_we)) begin
            buf_valid_r <= 1'b0;
        end else if ((state_r == CPU_WAIT) && bus.mem_ready && cpu_rd_r) begin
            buf_valid_r <= 1'b1;
            buf_tag_r   <= mem_addr_r;
            buf_data_r  <= bus.mem_dout;
        end else begin
            buf_valid_r <= buf_valid_r;
        end
    end
`else
    assign hit_s      = 1'b0;
    assign hit_data_s = 8'h00;
`endif

    assign bus.mem_rd   = mem_rd_r;
    assign bus.mem_we   = mem_we_r;
    assign bus.mem_addr = mem_addr_r;
    assign bus.mem_din  = mem_din_r;
    assign bus.cpu_dout = cpu_dout_r;
    assign bus.cpu_ack  = cpu_ack_r;
    assign bus.dma_ack  = dma_ack_r;
    assign grant_dma    = grant_dma_r;
    assign busy         = busy_r;
endmodule

// File: tb/tb_zx_ram_arbiter.sv
// Scoreboard bench for zx_ram_arbiter: requester tasks queue expected responses, a monitor pops them on
// every ack, and a behavioural SDRAM responder models acceptance and a configurable turnaround.
module tb_zx_ram_arbiter;
    localparam int AW           = 16;
    localparam int STARVE_LIMIT = 8;
`ifdef ARB_RDCACHE_EN
    localparam int HIT_LAT = 2;
    localparam int HIT_RDS = 0;
`else
    localparam int HIT_LAT = 4;
    localparam int HIT_RDS = 1;
`endif

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    logic grant_dma;
    logic busy;

    int   checks = 0;
    int   errors = 0;
    exp_t cpu_q[$];
    exp_t dma_q[$];
    logic ack_log[$];
    int   cpu_ack_cnt  = 0;
    int   dma_ack_cnt  = 0;
    int   rd_cycles    = 0;
    logic prev_cpu_ack = 1'b0;
    logic prev_dma_ack = 1'b0;

    logic [7:0] mem_arr [0:65535];
    int         turn_k   = 0;
    int         turn_cnt = 0;
    logic       hold_low = 1'b0;
    logic       rd_pend  = 1'b0;
    logic [7:0] rd_data  = 8'h00;

    zx_ram_arbiter_if #(.AW(AW)) bus ();

    zx_ram_arbiter #(.AW(AW), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .bus       (bus),
        .grant_dma (grant_dma),
        .busy      (busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: at each falling edge decides mem_ready/mem_dout for the next rising edge
    always @(negedge clk_sys) begin
        if (turn_cnt > 0) begin
            bus.mem_ready = 1'b0;
            turn_cnt--;
        end else if (hold_low) begin
            bus.mem_ready = 1'b0;
        end else begin
            bus.mem_ready = 1'b1;
            if (rd_pend) begin
                bus.mem_dout = rd_data;
                rd_pend      = 1'b0;
            end
        end
        if ((bus.mem_rd || bus.mem_we) && bus.mem_ready) begin
            turn_cnt = turn_k;
            if (bus.mem_we) begin
                mem_arr[bus.mem_addr] = bus.mem_din;
            end else begin
                rd_data      = mem_arr[bus.mem_addr];
                rd_pend      = 1'b1;
                bus.mem_dout = 8'hEE;
            end
        end
    end

    // Monitor: pops the owner's expected response on every ack and watches grant/strobe rules
    always @(negedge clk_sys) begin
        exp_t e;
        if (!reset) begin
            if (bus.mem_rd) rd_cycles++;
            if (!busy) check("grant_while_idle", 32'(grant_dma), 32'd0);
            if (grant_dma) begin
                check("dma_mem_rd", 32'(bus.mem_rd), 32'd0);
                check("dma_grant_addr", 32'(bus.mem_addr), 32'(bus.dma_addr));
            end
            if (bus.cpu_ack) begin
                cpu_ack_cnt++;
                ack_log.push_back(1'b0);
                check("cpu_ack_pulse", 32'(prev_cpu_ack), 32'd0);
                check("ack_exclusive", 32'(bus.dma_ack), 32'd0);
                if (cpu_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cpu_ack_unexpected: ack with 0 accesses outstanding, need >= 1");
                end else begin
                    e = cpu_q.pop_front();
                    if (e.we) check("cpu_wr_data", 32'(mem_arr[e.addr]), 32'(e.data));
                    else      check("cpu_rd_data", 32'(bus.cpu_dout), 32'(e.data));
                end
            end
            if (bus.dma_ack) begin
                dma_ack_cnt++;
                ack_log.push_back(1'b1);
                check("dma_ack_pulse", 32'(prev_dma_ack), 32'd0);
                if (dma_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dma_ack_unexpected: ack with 0 accesses outstanding, need >= 1");
                end else begin
                    e = dma_q.pop_front();
                    check("dma_wr_data", 32'(mem_arr[e.addr]), 32'(e.data));
                end
            end
        end
        prev_cpu_ack = bus.cpu_ack;
        prev_dma_ack = bus.dma_ack;
    end

    task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [7:0] data,
                              output int lat);
        cpu_q.push_back({we, addr, data});
        bus.cpu_we   = we;
        bus.cpu_addr = addr;
        bus.cpu_din  = data;
        bus.cpu_req  = 1'b1;
        lat = 0;
        do begin
            @(negedge clk_sys);
            lat++;
        end while (!bus.cpu_ack && lat < 300);
        if (!bus.cpu_ack) begin
            checks++;
            errors++;
            $display("FAIL cpu_timeout: no cpu_ack after %0d cycles, need ack", lat);
        end
        bus.cpu_req = 1'b0;
    endtask

    task automatic dma_access(input logic [15:0] addr, input logic [7:0] data);
        int n;
        dma_q.push_back({1'b1, addr, data});
        bus.dma_addr = addr;
        bus.dma_din  = data;
        bus.dma_req  = 1'b1;
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (!bus.dma_ack && n < 300);
        if (!bus.dma_ack) begin
            checks++;
            errors++;
            $display("FAIL dma_timeout: no dma_ack after %0d cycles, need ack", n);
        end
        bus.dma_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int rd0;
        int c0;
        int d0;
        int n0;
        int cpu_before;
        int waited;
        bus.cpu_req  = 1'b0;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 16'h0000;
        bus.cpu_din  = 8'h00;
        bus.dma_req  = 1'b0;
        bus.dma_addr = 16'h0000;
        bus.dma_din  = 8'h00;
        mem_arr[16'h4000] = 8'hA5;
        mem_arr[16'h4010] = 8'h3C;
        repeat (3) @(negedge clk_sys);

        check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
        check("rst_dma_ack", 32'(bus.dma_ack), 32'd0);
        check("rst_grant", 32'(grant_dma), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cpu_dout", 32'(bus.cpu_dout), 32'h00);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'h0000);
        check("rst_mem_din", 32'(bus.mem_din), 32'h00);
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);

        // 1: CPU read with a 2-cycle turnaround
        @(posedge clk_sys); #1 turn_k = 2;
        @(negedge clk_sys);
        rd0 = rd_cycles;
        cpu_access(1'b0, 16'h4000, 8'hA5, lat);
        check("t1_latency", lat, 32'd5);
        check("t1_rd_cycles", rd_cycles - rd0, 32'd1);
        repeat (3) @(negedge clk_sys);
        check("t1_dout_held", 32'(bus.cpu_dout), 32'hA5);

        // 2: simultaneous requests, CPU first
        @(posedge clk_sys); #1 turn_k = 0;
        @(negedge clk_sys);
        c0 = cpu_ack_cnt; d0 = dma_ack_cnt; n0 = ack_log.size();
        fork
            cpu_access(1'b1, 16'h6000, 8'h11, lat);
            dma_access(16'h7000, 8'h22);
        join
        repeat (4) @(negedge clk_sys);
        check("t2_cpu_lat", lat, 32'd3);
        check("t2_cpu_acks", cpu_ack_cnt - c0, 32'd1);
        check("t2_dma_acks", dma_ack_cnt - d0, 32'd1);
        check("t2_first_is_cpu", 32'(ack_log[n0]), 32'd0);
        check("t2_second_is_dma", 32'(ack_log[n0 + 1]), 32'd1);

        // 3: CPU hogging, DMA must win after STARVE_LIMIT lost arbitrations
        n0 = ack_log.size();
        fork
            begin
                for (int i = 0; i < 10; i++)
                    cpu_access(1'b1, 16'(16'h6100 + i), 8'(8'h30 + i), lat);
            end
            dma_access(16'h7100, 8'h55);
        join
        repeat (3) @(negedge clk_sys);
        cpu_before = 0;
        for (int i = n0; i < ack_log.size(); i++) begin
            if (ack_log[i]) break;
            cpu_before++;
        end
        check("t3_cpu_before_dma", cpu_before, 32'(STARVE_LIMIT));
        check("t3_total_acks", ack_log.size() - n0, 32'd11);
        check("t3_last_cpu_lat", lat, 32'd4);

        // 4: reset while DMA waits for completion
        @(posedge clk_sys); #1 turn_k = 6;
        @(negedge clk_sys);
        d0 = dma_ack_cnt;
        bus.dma_addr = 16'h7200;
        bus.dma_din  = 8'h66;
        bus.dma_req  = 1'b1;
        waited = 0;
        while (!(grant_dma && !bus.mem_we && busy) && waited < 20) begin
            @(negedge clk_sys);
            waited++;
        end
        check("t4_reached_wait", 32'(grant_dma && !bus.mem_we), 32'd1);
        reset = 1'b1;
        bus.dma_req = 1'b0;
        @(negedge clk_sys);
        check("t4_rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        check("t4_rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("t4_rst_dma_ack", 32'(bus.dma_ack), 32'd0);
        check("t4_rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
        check("t4_rst_busy", 32'(busy), 32'd0);
        check("t4_rst_grant", 32'(grant_dma), 32'd0);
        check("t4_rst_cpu_dout", 32'(bus.cpu_dout), 32'h00);
        reset = 1'b0;
        repeat (10) @(negedge clk_sys);
        check("t4_no_dma_ack", dma_ack_cnt - d0, 32'd0);
        @(posedge clk_sys); #1 turn_k = 0;
        @(negedge clk_sys);
        cpu_access(1'b0, 16'h4000, 8'hA5, lat);

        // 5: memory not ready for 20 cycles during a CPU write
        @(posedge clk_sys); #1 hold_low = 1'b1;
        @(negedge clk_sys);
        fork
            cpu_access(1'b1, 16'h6200, 8'h9A, lat);
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk_sys);
                    check("t5_we_held", 32'(bus.mem_we), 32'd1);
                    check("t5_addr_stable", 32'(bus.mem_addr), 32'h6200);
                    check("t5_din_stable", 32'(bus.mem_din), 32'h9A);
                end
                @(posedge clk_sys); #1 hold_low = 1'b0;
                @(negedge clk_sys);
                @(negedge clk_sys);
                check("t5_accept_first_ready", 32'(bus.mem_we), 32'd0);
            end
        join

        // 6: repeated read of one address, then a DMA write, then the read again
        @(posedge clk_sys); #1 turn_k = 1;
        @(negedge clk_sys);
        rd0 = rd_cycles;
        cpu_access(1'b0, 16'h4010, 8'h3C, lat);
        check("t6_first_lat", lat, 32'd4);
        check("t6_first_rds", rd_cycles - rd0, 32'd1);
        @(negedge clk_sys);
        rd0 = rd_cycles;
        cpu_access(1'b0, 16'h4010, 8'h3C, lat);
        check("t6_second_lat", lat, 32'(HIT_LAT));
        check("t6_second_rds", rd_cycles - rd0, 32'(HIT_RDS));
        @(negedge clk_sys);
        dma_access(16'h5000, 8'h44);
        @(negedge clk_sys);
        rd0 = rd_cycles;
        cpu_access(1'b0, 16'h4010, 8'h3C, lat);
        check("t6_third_lat", lat, 32'd4);
        check("t6_third_rds", rd_cycles - rd0, 32'd1);

        repeat (5) @(negedge clk_sys);
        check("cpu_queue_drained", cpu_q.size(), 32'd0);
        check("dma_queue_drained", dma_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
